dac5571_i2c_responder: RTL and testbench

I2C slave that models a TI DAC5571 on the bus: it answers its 7-bit address, accepts two-byte write frames carrying power-down bits and an 8-bit code, and serves two-byte read-back. It sits on the FPGA side as a loopback and verification target for our DAC-setting I2C master, and as a drop-in register source for boards without the physical DAC. It presents the decoded code and power-down bits as registered outputs with a one-cycle update strobe.

---
 rtl/dac5571_i2c_responder.sv | 195 +++++++++++++++++++
 tb/tb_dac5571_i2c_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac5571_i2c_responder.sv
// I2C responder emulating a TI DAC5571: answers its 7-bit address, takes
// two-byte writes into vol/pd, and serves two-byte read-back.
// Ports: sclk/nrst system clock and async active-low reset; scl/sda bus pins
// (sda open-drain); vol/pd decoded registers; vol_valid update strobe;
// busy while an addressed frame is in progress.
module dac5571_i2c_responder #(
    parameter logic [6:0] i2c_equi_addr = 7'b1001_100
) (
    input  logic       sclk,
    input  logic       nrst,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] vol,
    output logic [1:0] pd,
    output logic       vol_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE,
        WR_ACK, RD_BYTE, RD_MACK, WAIT_STOP
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] scl_q, sda_q;
    logic       scl_s, scl_d, sda_s, sda_d;
    logic       scl_rise, scl_fall, start, stop;
    logic [2:0] cnt;
    logic [6:0] sh;
    logic [7:0] rx_byte;
    logic [5:0] hold;
    logic       byte_idx, rw, sda_low;
    logic       bit_last, addr_hit;
    logic [7:0] tx_byte;
    logic [2:0] tx_sel;

    logic shift_en, cnt_inc, addr_done, wr_done, mack_ok;
    logic sda_upd, sda_nxt;

    // Two sync stages, third stage only for edge detection.
    // Reset to the idle-high bus level so reset release makes no edges.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign scl_s    = scl_q[1];
    assign scl_d    = scl_q[2];
    assign sda_s    = sda_q[1];
    assign sda_d    = sda_q[2];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & scl_d & ~sda_s & sda_d;
    assign stop     = scl_s & scl_d & sda_s & ~sda_d;

    assign rx_byte  = {sh, sda_s};
    assign bit_last = scl_rise && (cnt == 3'd7);
    assign addr_hit = (rx_byte[7:1] == i2c_equi_addr);
    assign tx_byte  = byte_idx ? {vol[3:0], 4'b0000}
                               : {2'b00, pd, vol[7:4]};
    assign tx_sel   = 3'd7 - cnt;

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // sda_low doubles as the phase flag of the ACK states: first SCL fall
    // asserts the ACK, the second one ends it.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ADDR;
        end else if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR:
                    if (bit_last)
                        state_nxt = addr_hit ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:
                    if (scl_fall && sda_low)
                        state_nxt = rw ? RD_BYTE : WR_BYTE;
                WR_BYTE:
                    if (bit_last) state_nxt = WR_ACK;
                WR_ACK:
                    if (scl_fall && sda_low) state_nxt = WR_BYTE;
                RD_BYTE:
                    if (bit_last) state_nxt = RD_MACK;
                RD_MACK:
                    if (scl_rise)
                        state_nxt = sda_s ? WAIT_STOP : RD_BYTE;
                default: ;
            endcase
        end
    end

    always_comb begin
        shift_en  = 1'b0;
        cnt_inc   = 1'b0;
        addr_done = 1'b0;
        wr_done   = 1'b0;
        mack_ok   = 1'b0;
        sda_upd   = 1'b0;
        sda_nxt   = 1'b0;
        if (start || stop) begin
            sda_upd = 1'b1;
        end else begin
            case (state)
                ADDR: begin
                    shift_en  = scl_rise;
                    cnt_inc   = scl_rise;
                    addr_done = bit_last;
                end
                ADDR_ACK: begin
                    // On a read the ACK-ending fall also drives bit 7.
                    sda_upd = scl_fall;
                    sda_nxt = ~sda_low | (rw & ~tx_byte[7]);
                end
                WR_BYTE: begin
                    shift_en = scl_rise;
                    cnt_inc  = scl_rise;
                    wr_done  = bit_last;
                end
                WR_ACK: begin
                    sda_upd = scl_fall;
                    sda_nxt = ~sda_low;
                end
                RD_BYTE: begin
                    cnt_inc = scl_rise;
                    sda_upd = scl_fall;
                    sda_nxt = ~tx_byte[tx_sel];
                end
                RD_MACK: begin
                    sda_upd = scl_fall;
                    mack_ok = scl_rise & ~sda_s;
                end
                default: begin
                    sda_upd = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            cnt       <= 3'd0;
            sh        <= 7'd0;
            hold      <= 6'd0;
            byte_idx  <= 1'b0;
            rw        <= 1'b0;
            vol       <= 8'h00;
            pd        <= 2'b00;
            vol_valid <= 1'b0;
            busy      <= 1'b0;
            sda_low   <= 1'b0;
        end else begin
            vol_valid <= 1'b0;
            if (start || stop) begin
                // Drops any unpaired byte left in the holding register.
                cnt      <= 3'd0;
                byte_idx <= 1'b0;
                hold     <= 6'd0;
            end else begin
                if (cnt_inc) cnt <= cnt + 3'd1;
                if (shift_en) sh <= rx_byte[6:0];
                if (addr_done) begin
                    rw   <= rx_byte[0];
                    busy <= addr_hit;
                end
                if (wr_done) begin
                    byte_idx <= ~byte_idx;
                    if (!byte_idx) begin
                        hold <= rx_byte[5:0];
                    end else begin
                        vol       <= {hold[3:0], rx_byte[7:4]};
                        pd        <= hold[5:4];
                        vol_valid <= 1'b1;
                    end
                end
                if (mack_ok) byte_idx <= ~byte_idx;
            end
            if (stop) busy <= 1'b0;
            if (sda_upd) sda_low <= sda_nxt;
        end
    end

    assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dac5571_i2c_responder.sv
// Bench for dac5571_i2c_responder: bit-banged I2C master, frame-level
// model of the DAC registers, per-cycle output compare.
module tb_dac5571_i2c_responder;

    localparam int H = 10;

    logic       sclk = 1'b0;
    logic       nrst = 1'b0;
    logic       scl  = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic [7:0] vol;
    logic [1:0] pd;
    logic       vol_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    logic [9:0] plog[$];
    logic [7:0] rlog[$];
    logic [7:0] m_vol = 8'h00;
    logic [1:0] m_pd  = 2'b00;
    logic [7:0] fb[8];

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 sclk = ~sclk;

    dac5571_i2c_responder dut (
        .sclk      (sclk),
        .nrst      (nrst),
        .scl       (scl),
        .sda       (sda),
        .vol       (vol),
        .pd        (pd),
        .vol_valid (vol_valid),
        .busy      (busy)
    );

    function automatic logic sda_in();
        return (sda === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Every cycle: outputs hold the model value; a strobe must match the
    // oldest pending completed write pair.
    always @(negedge sclk) begin
        logic [9:0] e;
        if (!nrst) begin
            exp_q.delete();
            m_vol = 8'h00;
            m_pd  = 2'b00;
            chk("rst_vol", {24'd0, vol}, 0);
            chk("rst_pd", {30'd0, pd}, 0);
            chk("rst_valid", {31'd0, vol_valid}, 0);
        end else if (vol_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", {31'd0, vol_valid}, 0);
            end else begin
                e = exp_q.pop_front();
                m_vol = e[7:0];
                m_pd  = e[9:8];
                plog.push_back({pd, vol});
                chk("pulse_vol", {24'd0, vol}, {24'd0, e[7:0]});
                chk("pulse_pd", {30'd0, pd}, {30'd0, e[9:8]});
            end
        end else begin
            chk("hold_vol", {24'd0, vol}, {24'd0, m_vol});
            chk("hold_pd", {30'd0, pd}, {30'd0, m_pd});
        end
    end

    task automatic wt(input int n);
        repeat (n) @(posedge sclk);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        m_low = ~b;
        wt(H);
        scl = 1'b1;
        wt(H / 2);
        r = sda_in();
        wt(H / 2);
        scl = 1'b0;
        wt(2);
    endtask

    task automatic start_cond();
        m_low = 1'b0;
        wt(H);
        scl = 1'b1;
        wt(H);
        m_low = 1'b1;
        wt(H);
        scl = 1'b0;
        wt(2);
    endtask

    task automatic stop_cond();
        m_low = 1'b1;
        wt(H);
        scl = 1'b1;
        wt(H);
        m_low = 1'b0;
        wt(H);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(d[i], r);
            if (d[i]) chk("bus_echo", {31'd0, r}, 1);
        end
        clock_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            d[i] = r;
        end
        clock_bit(nack, r);
        if (nack) chk("nack_release", {31'd0, r}, 1);
    endtask

    task automatic wr_frame(input logic [7:0] addr, input int n,
                            input logic do_stop);
        logic       ack, hit;
        logic [7:0] hold;
        hold = 8'h00;
        hit = (addr[7:1] == 7'h4C) && !addr[0];
        start_cond();
        write_byte(addr, ack);
        chk("addr_ack", {31'd0, ack}, {31'd0, hit});
        chk("busy_addr", {31'd0, busy}, {31'd0, hit});
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) hold = fb[i];
            else if (hit)
                exp_q.push_back({hold[5:4], hold[3:0], fb[i][7:4]});
            write_byte(fb[i], ack);
            chk("data_ack", {31'd0, ack}, {31'd0, hit});
        end
        if (do_stop) begin
            stop_cond();
            wt(4);
            chk("busy_stop", {31'd0, busy}, 0);
        end
        chk("pulse_count", exp_q.size(), 0);
    endtask

    task automatic rd_frame(input int n);
        logic       ack;
        logic [7:0] d, e;
        start_cond();
        write_byte(8'h99, ack);
        chk("rd_addr_ack", {31'd0, ack}, 1);
        chk("rd_busy", {31'd0, busy}, 1);
        for (int i = 0; i < n; i++) begin
            e = (i % 2 == 0) ? {2'b00, m_pd, m_vol[7:4]}
                             : {m_vol[3:0], 4'h0};
            read_byte(i == n - 1, d);
            rlog.push_back(d);
            chk("rd_byte", {24'd0, d}, {24'd0, e});
        end
        wt(3);
        chk("rd_release", {31'd0, sda_in()}, 1);
        stop_cond();
        wt(4);
        chk("busy_stop", {31'd0, busy}, 0);
    endtask

    initial begin
        logic       ack, r;
        logic [7:0] addrs[4];
        int         n;
        addrs[0] = 8'h98;
        addrs[1] = 8'h98;
        addrs[2] = 8'h9A;
        addrs[3] = 8'h9B;

        wt(5);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_sda", {31'd0, sda_in()}, 1);
        nrst = 1'b1;
        wt(5);

        fb[0] = 8'h0A; fb[1] = 8'h50;
        wr_frame(8'h98, 2, 1'b1);
        chk("t1_vol", {24'd0, vol}, 32'hA5);
        chk("t1_pd", {30'd0, pd}, 0);

        fb[0] = 8'h11; fb[1] = 8'h22;
        wr_frame(8'h9A, 2, 1'b1);
        chk("wrong_vol", {24'd0, vol}, 32'hA5);
        chk("wrong_busy", {31'd0, busy}, 0);

        rlog.delete();
        rd_frame(2);
        chk("rd_a", {24'd0, rlog[0]}, 32'h0A);
        chk("rd_b", {24'd0, rlog[1]}, 32'h50);

        plog.delete();
        fb[0] = 8'h3F; fb[1] = 8'hF0; fb[2] = 8'h01; fb[3] = 8'h20;
        wr_frame(8'h98, 4, 1'b1);
        chk("t2_npulse", plog.size(), 2);
        chk("t2_p0", {22'd0, plog[0]}, {22'd0, 2'b11, 8'hFF});
        chk("t2_p1", {22'd0, plog[1]}, {22'd0, 2'b00, 8'h12});

        fb[0] = 8'h0C;
        wr_frame(8'h98, 1, 1'b1);
        chk("odd_vol", {24'd0, vol}, 32'h12);

        wr_frame(8'h98, 1, 1'b0);
        fb[0] = 8'h01; fb[1] = 8'h80;
        wr_frame(8'h98, 2, 1'b1);
        chk("rs_vol", {24'd0, vol}, 32'h18);
        chk("rs_pd", {30'd0, pd}, 0);

        start_cond();
        write_byte(8'h98, ack);
        write_byte(8'h0B, ack);
        clock_bit(1'b1, r);
        clock_bit(1'b0, r);
        clock_bit(1'b1, r);
        clock_bit(1'b0, r);
        m_low = 1'b0;
        @(posedge sclk);
        #1 nrst = 1'b0;
        wt(2);
        chk("mid_vol", {24'd0, vol}, 0);
        chk("mid_pd", {30'd0, pd}, 0);
        chk("mid_valid", {31'd0, vol_valid}, 0);
        chk("mid_busy", {31'd0, busy}, 0);
        chk("mid_sda", {31'd0, sda_in()}, 1);
        wt(3);
        nrst = 1'b1;
        wt(2);
        scl = 1'b1;
        wt(H);
        fb[0] = 8'h03; fb[1] = 8'hC0;
        wr_frame(8'h98, 2, 1'b1);
        chk("post_vol", {24'd0, vol}, 32'h3C);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 3) == 3) begin
                rd_frame($urandom_range(1, 3));
            end else begin
                n = $urandom_range(1, 5);
                for (int i = 0; i < n; i++)
                    fb[i] = 8'($urandom_range(0, 255));
                wr_frame(addrs[$urandom_range(0, 3)], n,
                         $urandom_range(0, 3) != 0);
            end
        end
        stop_cond();
        wt(10);
        chk("final_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
